// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matvec engine: FSM state, legality limits, fixed-point narrowing.
// MATVEC_SAT_EN selects saturating narrowing in fx_narrow; otherwise results wrap.
package matvec_pkg;

   localparam int unsigned DimMin   = 2;
   localparam int unsigned DimMax   = 8;
   localparam int unsigned MaxW     = 64;
   localparam int unsigned AccMaxW  = 2 * MaxW + $clog2(DimMax);

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDone
   } state_e;

   typedef struct packed {
      logic            ovf;
      logic [MaxW-1:0] val;
   } narrow_t;

   // Arithmetic shift (floor) by frac, then narrow to width bits by clamping or wrapping.
   function automatic narrow_t fx_narrow(input logic signed [AccMaxW-1:0] acc,
                                         input int unsigned frac,
                                         input int unsigned width);
      narrow_t                   res;
      logic signed [AccMaxW-1:0] shifted;
`ifdef MATVEC_SAT_EN
      logic signed [AccMaxW-1:0] hi;
      logic signed [AccMaxW-1:0] lo;
`else
      logic [MaxW-1:0]           mask;
`endif
      shifted = acc >>> frac;
      res.ovf = 1'b0;
`ifdef MATVEC_SAT_EN
      hi = (AccMaxW'(1) << (width - 1)) - AccMaxW'(1);
      lo = ~hi;
      if (shifted > hi) begin
         res.ovf = 1'b1;
         res.val = hi[MaxW-1:0];
      end else if (shifted < lo) begin
         res.ovf = 1'b1;
         res.val = lo[MaxW-1:0];
      end else begin
         res.val = shifted[MaxW-1:0];
      end
`else
      mask    = (MaxW'(1) << width) - MaxW'(1);
      res.val = shifted[MaxW-1:0] & mask;
`endif
      return res;
   endfunction

endpackage

// File: rtl/matvec_lane.sv
// One row lane: registered product, wide accumulator, and narrowed result latched on completion.
module matvec_lane
   import matvec_pkg::*;
#(
   parameter int unsigned DIM   = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             mul_i,
   input  logic             acc_i,
   input  logic             fin_i,
   input  logic [WIDTH-1:0] m_i,
   input  logic [WIDTH-1:0] v_i,
   output logic [WIDTH-1:0] res_o,
   output logic             ovf_o
);

   localparam int unsigned AW = 2 * WIDTH + $clog2(DIM);

   logic signed [2*WIDTH-1:0] prod_d, prod_q;
   logic signed [AW-1:0]      acc_d, acc_q, acc_sum;
   logic [WIDTH-1:0]          res_q;
   logic                      ovf_q;
   narrow_t                   nar;

   assign prod_d  = $signed(m_i) * $signed(v_i);
   assign acc_sum = acc_q + AW'(prod_q);
   // The final product is folded in combinationally so the result lands on the DONE entry edge.
   assign nar     = fx_narrow(AccMaxW'(acc_sum), FRAC, WIDTH);

   if (WIDTH < MaxW) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^nar.val[MaxW-1:WIDTH];
   end

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (acc_i) begin
         acc_d = acc_sum;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prod_q <= '0;
         acc_q  <= '0;
         res_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (mul_i) begin
            prod_q <= prod_d;
         end
         acc_q <= acc_d;
         if (fin_i) begin
            res_q <= nar.val[WIDTH-1:0];
            ovf_q <= nar.ovf;
         end
      end
   end

   assign res_o = res_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/matvec_engine.sv
// Fixed-point y = M * v engine: matrix bank, vector latch, column FSM and DIM parallel lanes.
// Define MATVEC_SAT_EN for saturating narrowing and the ovf_out port; default build wraps.
module matvec_engine
   import matvec_pkg::*;
#(
   parameter int unsigned DIM   = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 16
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [DIM*DIM*WIDTH-1:0] mat_in,
   input  logic                     mat_load_in,
   output logic                     mat_ready_out,
   input  logic [DIM*WIDTH-1:0]     vec_in,
   input  logic                     vec_valid_in,
   output logic                     vec_ready_out,
   output logic [DIM*WIDTH-1:0]     res_out,
   output logic                     res_valid_out,
   input  logic                     res_ready_in,
   output logic                     busy_out
`ifdef MATVEC_SAT_EN
   ,
   output logic                     ovf_out
`endif
);

   localparam int unsigned CW = $clog2(DIM + 1);
   localparam int unsigned IW = (DIM > 1) ? $clog2(DIM) : 1;

   state_e                   state_q, state_d;
   logic [CW-1:0]            col_q, col_d;
   logic [IW-1:0]            col_idx;
   logic [DIM*DIM*WIDTH-1:0] bank_q;
   logic [DIM*WIDTH-1:0]     vec_q;
   logic                     accept, load, mul_en, acc_en, fin;
   logic [DIM-1:0]           lane_ovf;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= StIdle;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
      end
   end

   // ACCUM runs DIM+1 cycles: col 0..DIM-1 multiply, col 1..DIM accumulate the registered product.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      unique case (state_q)
         StIdle: begin
            if (vec_valid_in) begin
               state_d = StAccum;
               col_d   = '0;
            end
         end
         StAccum: begin
            if (col_q == CW'(DIM)) begin
               state_d = StDone;
               col_d   = '0;
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         StDone: begin
            if (res_ready_in) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mat_ready_out = 1'b0;
      vec_ready_out = 1'b0;
      res_valid_out = 1'b0;
      busy_out      = 1'b1;
      accept        = 1'b0;
      load          = 1'b0;
      mul_en        = 1'b0;
      acc_en        = 1'b0;
      fin           = 1'b0;
      unique case (state_q)
         StIdle: begin
            mat_ready_out = 1'b1;
            vec_ready_out = 1'b1;
            busy_out      = 1'b0;
            accept        = vec_valid_in;
            load          = mat_load_in;
         end
         StAccum: begin
            mul_en = (col_q != CW'(DIM));
            acc_en = (col_q != '0);
            fin    = (col_q == CW'(DIM));
         end
         StDone:  res_valid_out = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bank_q <= '0;
         vec_q  <= '0;
      end else begin
         if (load) begin
            bank_q <= mat_in;
         end
         if (accept) begin
            vec_q <= vec_in;
         end
      end
   end

   assign col_idx = (col_q < CW'(DIM)) ? col_q[IW-1:0] : '0;

   for (genvar r = 0; r < DIM; r++) begin : g_lane
      matvec_lane #(
         .DIM   (DIM),
         .WIDTH (WIDTH),
         .FRAC  (FRAC)
      ) u_lane (
         .clk_i (clk_in),
         .rst_i (rst_in),
         .clr_i (accept),
         .mul_i (mul_en),
         .acc_i (acc_en),
         .fin_i (fin),
         .m_i   (bank_q[(r * DIM + int'(col_idx)) * WIDTH +: WIDTH]),
         .v_i   (vec_q[int'(col_idx) * WIDTH +: WIDTH]),
         .res_o (res_out[r*WIDTH +: WIDTH]),
         .ovf_o (lane_ovf[r])
      );
   end

`ifdef MATVEC_SAT_EN
   assign ovf_out = |lane_ovf;
`else
   logic unused_ovf;
   assign unused_ovf = |lane_ovf;
`endif

endmodule

// File: tb/tb_matvec_engine.sv
// Self-checking bench for matvec_engine (DIM=4, WIDTH=32, FRAC=16); honours MATVEC_SAT_EN.
module tb_matvec_engine;

   typedef logic [15:0][31:0] mat_t;
   typedef logic [3:0][31:0]  vec_t;
   typedef struct packed {
      vec_t res;
      logic ovf;
   } out_t;
   typedef struct {
      string name;
      mat_t  m;
      vec_t  v;
      out_t  exp;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   mat_t mat_in = '0;
   logic mat_load = 1'b0;
   logic mat_ready;
   vec_t vec_in = '0;
   logic vec_valid = 1'b0;
   logic vec_ready;
   vec_t res_out;
   logic res_valid;
   logic res_ready = 1'b0;
   logic busy;
`ifdef MATVEC_SAT_EN
   logic ovf;
`endif

   int   n_chk  = 0;
   int   n_pass = 0;
   out_t sb[$];
   mat_t cur_m = '0;
   rec_t tbl[4];

   always #5 clk = ~clk;

   matvec_engine #(
      .DIM   (4),
      .WIDTH (32),
      .FRAC  (16)
   ) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .mat_in        (mat_in),
      .mat_load_in   (mat_load),
      .mat_ready_out (mat_ready),
      .vec_in        (vec_in),
      .vec_valid_in  (vec_valid),
      .vec_ready_out (vec_ready),
      .res_out       (res_out),
      .res_valid_out (res_valid),
      .res_ready_in  (res_ready),
      .busy_out      (busy)
`ifdef MATVEC_SAT_EN
      ,
      .ovf_out       (ovf)
`endif
   );

   function automatic mat_t diag(input logic [31:0] d);
      mat_t m = '0;
      for (int i = 0; i < 4; i++) m[i*5] = d;
      return m;
   endfunction

   function automatic mat_t fill(input logic [31:0] d);
      mat_t m;
      for (int i = 0; i < 16; i++) m[i] = d;
      return m;
   endfunction

   function automatic vec_t mkvec(input logic [31:0] a, b, c, d);
      vec_t v;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      return v;
   endfunction

   function automatic out_t model(input mat_t m, input vec_t v);
      out_t o;
      logic signed [127:0] sum, a, b, sh;
      o.ovf = 1'b0;
      for (int r = 0; r < 4; r++) begin
         sum = '0;
         for (int c = 0; c < 4; c++) begin
            a = $signed(m[r*4+c]);
            b = $signed(v[c]);
            sum = sum + a * b;
         end
         sh = sum >>> 16;
`ifdef MATVEC_SAT_EN
         if (sh > 128'sd2147483647) begin
            o.res[r] = 32'h7FFFFFFF;
            o.ovf = 1'b1;
         end else if (sh < -128'sd2147483648) begin
            o.res[r] = 32'h80000000;
            o.ovf = 1'b1;
         end else begin
            o.res[r] = sh[31:0];
         end
`else
         o.res[r] = sh[31:0];
`endif
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic load_mat(input mat_t m);
      @(negedge clk);
      chk("mat_ready", mat_ready, 1'b1);
      mat_in = m;
      mat_load = 1'b1;
      cur_m = m;
      @(negedge clk);
      mat_load = 1'b0;
   endtask

   task automatic send(input vec_t v, input out_t exp);
      int n = 0;
      @(negedge clk);
      while (!vec_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!vec_ready) begin
         n_chk++;
         $display("FAIL send_timeout: vec_ready_out still 0 after %0d cycles", n);
      end
      vec_in = v;
      vec_valid = 1'b1;
      sb.push_back(exp);
      @(negedge clk);
      vec_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) begin
         n_chk++;
         $display("FAIL %s_timeout: res_valid_out still 0 after %0d cycles", name, n);
      end
   endtask

   task automatic get(input string name);
      out_t e;
      wait_valid(name);
      if (sb.size() == 0) begin
         n_chk++;
         $display("FAIL %s: result present but nothing expected", name);
      end else begin
         e = sb.pop_front();
         chk(name, res_out, e.res);
`ifdef MATVEC_SAT_EN
         chk({name, "_ovf"}, ovf, e.ovf);
`endif
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({name, "_drop"}, res_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      vec_t v;
      out_t e;

      tbl[0] = '{"half_zero", fill(32'h00008000),
                 mkvec(32'hFFFE0000, 32'h00040000, 32'h00060000, 32'hFFF80000),
                 '{res: '0, ovf: 1'b0}};
      tbl[1] = '{"half_ones", fill(32'h00008000),
                 mkvec(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000),
                 '{res: mkvec(32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000),
                   ovf: 1'b0}};
      tbl[2] = '{"floor", diag(32'h00018000),
                 mkvec(32'hFFFFFFFF, 32'h00000001, 32'h00010000, 32'hFFFF0000),
                 '{res: mkvec(32'hFFFFFFFE, 32'h00000001, 32'h00018000, 32'hFFFE8000),
                   ovf: 1'b0}};
`ifdef MATVEC_SAT_EN
      tbl[3] = '{"big", fill(32'h7FFF0000), mkvec(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000,
                 32'h7FFF0000), '{res: mkvec(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                 32'h7FFFFFFF), ovf: 1'b1}};
`else
      tbl[3] = '{"big", fill(32'h7FFF0000), mkvec(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000,
                 32'h7FFF0000), '{res: mkvec(32'h00040000, 32'h00040000, 32'h00040000,
                 32'h00040000), ovf: 1'b0}};
`endif

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", res_valid, 1'b0);
      chk("rst_res", res_out, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_vready", vec_ready, 1'b1);
      chk("rst_mready", mat_ready, 1'b1);
      rst = 1'b0;

      // Identity matrix and accept-to-valid latency
      load_mat(diag(32'h00010000));
      @(negedge clk);
      v = mkvec(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
      vec_in = v;
      vec_valid = 1'b1;
      sb.push_back('{res: v, ovf: 1'b0});
      @(posedge clk);
      #1 vec_valid = 1'b0;
      chk("acc_busy", busy, 1'b1);
      chk("acc_vready", vec_ready, 1'b0);
      lat = 0;
      while (!res_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("latency", lat, 5);
      @(negedge clk);
      get("ident");

      // Table-driven vectors
      for (int i = 0; i < 4; i++) begin
         load_mat(tbl[i].m);
         send(tbl[i].v, tbl[i].exp);
         get(tbl[i].name);
      end

      // Backpressure in DONE with a competing vector
      load_mat(diag(32'h00010000));
      v = mkvec(32'h00050000, 32'hFFFF0000, 32'h00000007, 32'h12340000);
      e = model(cur_m, v);
      send(v, e);
      wait_valid("bp_wait");
      vec_in = mkvec(32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000);
      vec_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_res", res_out, e.res);
         chk("bp_vready", vec_ready, 1'b0);
         chk("bp_valid", res_valid, 1'b1);
      end
      vec_valid = 1'b0;
      get("bp");
      chk("bp_idle", busy, 1'b0);
      v = mkvec(32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000);
      send(v, model(cur_m, v));
      get("bp_next");

      // Load pulsed during ACCUM is dropped
      v = mkvec(32'h00030000, 32'h00010000, 32'hFFFE0000, 32'h00008000);
      send(v, model(cur_m, v));
      chk("accum_mready", mat_ready, 1'b0);
      mat_in = diag(32'h00020000);
      mat_load = 1'b1;
      @(negedge clk);
      mat_load = 1'b0;
      get("ld_ignored");
      send(v, model(cur_m, v));
      get("ld_ignored_next");

      // Reset during ACCUM at col=2
      load_mat(fill(32'h00010000));
      v = mkvec(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
      send(v, model(cur_m, v));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", res_valid, 1'b0);
      chk("mid_rst_res", res_out, '0);
      rst = 1'b0;
      sb.delete();
      cur_m = '0;
      send(v, model(cur_m, v));
      get("post_rst_zero");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
